// File: rtl/fpu_pkg.sv
// Shared FPU definitions: scheduler states, default mantissa width and requester ids.
package fpu_pkg;

  localparam int MANT_W = 24;

  localparam logic REQ_FMUL = 1'b0;
  localparam logic REQ_ITER = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: purely combinational grant from request valids and last winner.
module rr_arb2
  import fpu_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       grant_id
);

  // NOTE: every output of a combinational block is given a default first, so no path leaves a latch.
  always_comb begin
    grant    = 2'b00;
    grant_id = REQ_FMUL;
    unique case (valid)
      2'b01: grant_id = REQ_FMUL;
      2'b10: grant_id = REQ_ITER;
      2'b11: grant_id = (last_grant == REQ_FMUL) ? REQ_ITER : REQ_FMUL;
      default: grant_id = REQ_FMUL;
    endcase
    if (valid != 2'b00) grant = grant_id ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/mant_mul_sched.sv
// Shares one iterative mantissa multiplier core between the FMUL and FMA/divide-iteration
// requesters: round-robin accept, core load pulse, watchdog-guarded run, valid/ready response.
module mant_mul_sched
  import fpu_pkg::*;
#(
  parameter int N       = MANT_W,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [N-1:0]     req_a0,
  input  logic [N-1:0]     req_b0,
  input  logic [N-1:0]     req_a1,
  input  logic [N-1:0]     req_b1,
  output logic             core_load,
  output logic [N-1:0]     core_a,
  output logic [N-1:0]     core_b,
  input  logic             core_done,
  input  logic [2*N-1:0]   core_prod,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [2*N-1:0]   rsp_prod,
  output logic             rsp_err,
  output logic             busy
);

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  sched_state_t    state, state_next;
  logic            last_grant;
  logic [WD_W-1:0] watchdog;
  logic [1:0]      grant;
  logic            grant_id;
  logic            accept;

  rr_arb2 u_arb (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  // Only IDLE may accept, so a response never blocks on rsp_ready through req_ready.
  assign req_ready = (state == IDLE) ? grant : 2'b00;
  assign accept    = |req_ready;

  assign core_load = (state == LOAD);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = LOAD;
      LOAD: state_next = RUN;
      RUN:  if (core_done || watchdog == WD_LAST) state_next = RESP;
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Last grant resets to the iteration port so the FMUL port wins the first contested cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant <= REQ_ITER;
      watchdog   <= '0;
      core_a     <= '0;
      core_b     <= '0;
      rsp_id     <= REQ_FMUL;
      rsp_prod   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            core_a     <= grant_id ? req_a1 : req_a0;
            core_b     <= grant_id ? req_b1 : req_b0;
            rsp_id     <= grant_id;
            last_grant <= grant_id;
          end
        end
        LOAD: watchdog <= '0;
        RUN: begin
          watchdog <= watchdog + 1'b1;
          // A completion on the expiry cycle still counts as a good result.
          if (core_done) begin
            rsp_prod <= core_prod;
            rsp_err  <= 1'b0;
          end else if (watchdog == WD_LAST) begin
            rsp_prod <= '0;
            rsp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mant_mul_sched.md
Name: mant_mul_sched

Overview:
- Shares one iterative radix-4 Booth mantissa multiplier core between two requesters, the FP multiply path (port 0) and the FMA/divide-iteration path (port 1).
- Arbitrates round-robin, latches operands, and pulses the core's load. It then waits for core completion with a watchdog and returns the product, tagged with the requester id, over a valid/ready response channel.
- Sits between the FPU issue logic and the multiplier core.

Parameters:
- N, 24, mantissa operand width (product is 2N).
- TIMEOUT, 16, max RUN cycles before the watchdog fires (must exceed N/2+2).

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- req_valid  in  2  request valid per requester
- req_ready  out  2  request accepted this cycle, per requester
- req_a0, req_b0  in  N each  requester 0 operands
- req_a1, req_b1  in  N each  requester 1 operands
- core_load  out  1  one-cycle pulse that starts the core
- core_a, core_b  out  N each  latched operands, stable from LOAD through RUN
- core_done  in  1  core result valid (one-cycle pulse)
- core_prod  in  2N  core product, sampled when core_done=1
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_id  out  1  requester id of the response
- rsp_prod  out  2N  product (0 on error)
- rsp_err  out  1  watchdog expired for this response
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rstn=0):
  - Outputs and state: state=IDLE; core_load=0; core_a=core_b=0; rsp_valid=0; rsp_id=0; rsp_prod=0; rsp_err=0; busy=0.
  - Internal: last_grant=1, so requester 0 wins first; watchdog=0.
  - Reset during any state aborts the operation. The in-flight request is lost and not replayed.
- Handshake rules:
  - req_ready is combinational and non-zero only in IDLE, at most one-hot.
  - req_ready depends on req_valid and last_grant only, never on rsp_ready.
  - A request transfers when req_valid[i] & req_ready[i].
- Arbitration (IDLE):
  - If only one req_valid is set, that requester is granted.
  - If both are set, grant the one != last_grant.
  - If none, stay in IDLE.
  - On transfer: latch the operands into core_a/core_b, latch id, set last_grant=id, go to LOAD.
- FSM:
  - IDLE -> LOAD on a transfer.
  - LOAD: core_load=1 for exactly this cycle; watchdog cleared; -> RUN.
  - RUN: watchdog increments each cycle.
    - If core_done=1: capture core_prod into rsp_prod, rsp_err=0, rsp_valid=1, -> RESP.
    - Else if watchdog==TIMEOUT-1: rsp_prod=0, rsp_err=1, rsp_valid=1, -> RESP.
    - core_done and watchdog expiry in the same cycle: core_done wins.
  - RESP: hold rsp_valid, rsp_id, rsp_prod and rsp_err stable until rsp_ready=1. On that cycle: rsp_valid=0, -> IDLE.
    - No new request is accepted in the RESP cycle. The earliest next accept is the following cycle.
- Ignored inputs: core_done outside RUN is ignored. core_prod is don't-care except when sampled.
- Latency: accept at cycle t; core_load at t+1; core_done at cycle d ≥ t+2 gives rsp_valid at d+1. Minimum throughput is one operation per (core latency + 3) cycles with rsp_ready held high.
- Watchdog counter width is $clog2(TIMEOUT+1). It never wraps, because it is cleared in LOAD.
- busy = (state != IDLE), registered-state decode.

Decomposition:
- Shared package fpu_pkg:
  - state enum sched_state_t {IDLE, LOAD, RUN, RESP} (2 bits).
  - Localparam default mantissa width MANT_W=24.
  - Requester id constants REQ_FMUL=0, REQ_ITER=1.
- One natural sub-module: rr_arb2 (2-way round-robin grant from valid and last_grant, purely combinational).
- Watchdog and FSM stay in the top module.

Test Plan:
1. Single request, port0 a=3, b=5, core_done 14 cycles after load with prod=15 -> req_ready[0]=1 at t, core_load at t+1, rsp_valid with id=0, prod=15, err=0 one cycle after done.
2. Both valid at once from reset -> port0 granted first. On the next IDLE, port1 is granted (a=0xFFFFFF, b=2, prod=0x1FFFFFE, id=1), then port0 again: strict alternation.
3. Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable all 5 cycles; req_ready=00 throughout; transfer completes when rsp_ready=1; IDLE on the next cycle.
4. Core never asserts done -> rsp_valid rises exactly TIMEOUT cycles after RUN entry, with rsp_err=1 and rsp_prod=0; the next request is then served normally.
5. core_done asserted on the same cycle the watchdog expires -> rsp_err=0, rsp_prod=core_prod. A spurious core_done pulse in IDLE -> no rsp_valid.
6. rstn pulled low mid-RUN -> all outputs zero asynchronously. After release, a request with both valid is granted to port0, and the core receives a fresh core_load pulse.
